// File: rtl/word_scrambler.sv
// Word scrambler: picks a ROM word with a free-running LFSR, presents a non-identity
// permutation to the swap stage and grades the returned guess. Optional: WORD_SCRAMBLER_SCORE_EN.
module word_scrambler #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         CHAR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_word,
    input  logic              sw_done,
    input  logic [CHAR_W-1:0] guess_char0,
    input  logic [CHAR_W-1:0] guess_char1,
    input  logic [CHAR_W-1:0] guess_char2,
    output logic [CHAR_W-1:0] scr_char0,
    output logic [CHAR_W-1:0] scr_char1,
    output logic [CHAR_W-1:0] scr_char2,
    output logic              load,
    output logic [2:0]        word_idx,
    output logic              busy,
    output logic              match,
`ifdef WORD_SCRAMBLER_SCORE_EN
    output logic [3:0]        score,
`endif
    output logic              mismatch
);

    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [2:0] {IDLE, PICK, SCRAMBLE, PRESENT, CHECK, RESULT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  lfsr;
    logic        sw_q;
    logic        sw_rise;
    logic [23:0] rom_w;
    logic [2:0]  sel;
    logic [CHAR_W-1:0] w0, w1, w2, p0, p1, p2;
    logic        guess_ok;

    function automatic logic [23:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = "CAT";
            3'd1:    rom = "DOG";
            3'd2:    rom = "SUN";
            3'd3:    rom = "BED";
            3'd4:    rom = "HAT";
            3'd5:    rom = "PEN";
            3'd6:    rom = "BUS";
            default: rom = "CUP";
        endcase
    endfunction

    assign rom_w    = rom(word_idx);
    assign w0       = CHAR_W'(rom_w[23:16]);
    assign w1       = CHAR_W'(rom_w[15:8]);
    assign w2       = CHAR_W'(rom_w[7:0]);
    assign sw_rise  = sw_done & ~sw_q;
    assign busy     = (state == PICK) || (state == SCRAMBLE);
    assign guess_ok = (guess_char0 == w0) && (guess_char1 == w1) && (guess_char2 == w2);

    // Selector codes 0, 6 and 7 fold onto real permutations so identity never appears.
    always_comb begin
        sel = lfsr[5:3];
        case (lfsr[5:3])
            3'd0:    sel = 3'd1;
            3'd6:    sel = 3'd2;
            3'd7:    sel = 3'd3;
            default: sel = lfsr[5:3];
        endcase
        p0 = w1; p1 = w0; p2 = w2;
        case (sel)
            3'd2:    begin p0 = w0; p1 = w2; p2 = w1; end
            3'd3:    begin p0 = w2; p1 = w1; p2 = w0; end
            3'd4:    begin p0 = w1; p1 = w2; p2 = w0; end
            3'd5:    begin p0 = w2; p1 = w0; p2 = w1; end
            default: begin p0 = w1; p1 = w0; p2 = w2; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (new_word) state_nxt = PICK;
            PICK:     state_nxt = SCRAMBLE;
            SCRAMBLE: state_nxt = PRESENT;
            PRESENT: begin
                if (new_word)     state_nxt = PICK;
                else if (sw_rise) state_nxt = CHECK;
            end
            CHECK:    state_nxt = RESULT;
            RESULT:   if (new_word) state_nxt = PICK;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lfsr  <= SEED;
            sw_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            sw_q  <= sw_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx  <= 3'd0;
            scr_char0 <= '0;
            scr_char1 <= '0;
            scr_char2 <= '0;
            load      <= 1'b0;
            match     <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            load <= (state == SCRAMBLE);
            if (state == PICK) word_idx <= lfsr[2:0];
            if (state == SCRAMBLE) begin
                scr_char0 <= p0;
                scr_char1 <= p1;
                scr_char2 <= p2;
            end
            if (state == CHECK) begin
                match    <= guess_ok;
                mismatch <= ~guess_ok;
            end
            if (state == RESULT && new_word) begin
                match    <= 1'b0;
                mismatch <= 1'b0;
            end
        end
    end

`ifdef WORD_SCRAMBLER_SCORE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            score <= 4'd0;
        else if (state == CHECK && guess_ok && score != 4'hF)
            score <= score + 4'd1;
    end
`endif

endmodule
